// File: rtl/tactile_scan_ctrl.sv
// Tactile array scan sequencer.
// Walks the analog mux over NUM_CH taxels, lets each one settle, fires a single
// conversion request at the serial ADC reader, and streams the tagged result.
// A reader that reports a sync error or never answers is reset and retried; a
// taxel that keeps failing is reported as a skipped (error) sample.
module tactile_scan_ctrl #(
    parameter int NUM_CH         = 16,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_in,
    input  logic                      continuous_in,
    input  logic                      adc_valid_in,
    input  logic                      adc_error_in,
    input  logic [11:0]               adc_data_in,
    output logic [$clog2(NUM_CH)-1:0] mux_sel_out,
    output logic                      adc_pulse_rd_out,
    output logic                      adc_rst_out,
    output logic                      sample_valid_out,
    output logic [$clog2(NUM_CH)-1:0] sample_ch_out,
    output logic [11:0]               sample_data_out,
    output logic                      sample_err_out,
    output logic                      frame_done_out,
    output logic                      busy_out,
    output logic                      fault_out,
    output logic [7:0]                err_count_out
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_TRIGGER = 3'd2,
        S_WAIT    = 3'd3,
        S_RECOVER = 3'd4,
        S_NEXT    = 3'd5
    } state_t;

    // Error counter increment that sticks at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [CH_W-1:0]   ch_r;
    logic [RTY_W-1:0]  retry_r;
    logic [SET_W-1:0]  settle_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              rec_cnt_r;

    logic              pulse_rd_r;
    logic              adc_rst_r;
    logic              sample_valid_r;
    logic [CH_W-1:0]   sample_ch_r;
    logic [11:0]       sample_data_r;
    logic              sample_err_r;
    logic              frame_done_r;
    logic              busy_r;
    logic              fault_r;
    logic [7:0]        err_count_r;

    logic              settle_done_s;
    logic              tmo_hit_s;
    logic              rec_done_s;
    logic              retry_ok_s;
    logic              last_ch_s;
    logic              start_ok_s;
    logic              accept_s;
    logic              rec_entry_s;
    logic              skip_s;

    // Decode of counter terminal values and the events the datapath reacts to.
    always_comb begin
        settle_done_s = (settle_cnt_r == SET_LAST);
        tmo_hit_s     = (tmo_cnt_r == TMO_LAST);
        rec_done_s    = rec_cnt_r;
        retry_ok_s    = (retry_r < RTY_MAX);
        last_ch_s     = (ch_r == LAST_CH);
        start_ok_s    = (state_r == S_IDLE) && start_in;
        accept_s      = (state_r == S_WAIT) && adc_valid_in;
        rec_entry_s   = (state_r == S_WAIT) && (next_state_s == S_RECOVER);
        skip_s        = (state_r == S_RECOVER) && rec_done_s && !retry_ok_s;
    end

    // Next-state logic; a valid result outranks a simultaneous error or timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_in) begin
                    next_state_s = S_SETTLE;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (settle_done_s) begin
                    next_state_s = S_TRIGGER;
                end else begin
                    next_state_s = S_SETTLE;
                end
            end
            S_TRIGGER: begin
                next_state_s = S_WAIT;
            end
            S_WAIT: begin
                if (adc_valid_in) begin
                    next_state_s = S_NEXT;
                end else if (adc_error_in || tmo_hit_s) begin
                    next_state_s = S_RECOVER;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_RECOVER: begin
                if (!rec_done_s) begin
                    next_state_s = S_RECOVER;
                end else if (retry_ok_s) begin
                    next_state_s = S_SETTLE;
                end else begin
                    next_state_s = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!last_ch_s || continuous_in) begin
                    next_state_s = S_SETTLE;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Settle, timeout and recovery-length counters; each idles at zero outside its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= {SET_W{1'b0}};
            tmo_cnt_r    <= {TMO_W{1'b0}};
            rec_cnt_r    <= 1'b0;
        end else begin
            if ((state_r == S_SETTLE) && !settle_done_s) begin
                settle_cnt_r <= settle_cnt_r + SET_W'(1);
            end else begin
                settle_cnt_r <= {SET_W{1'b0}};
            end
            if (state_r == S_WAIT) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end
            if (state_r == S_RECOVER) begin
                rec_cnt_r <= ~rec_cnt_r;
            end else begin
                rec_cnt_r <= 1'b0;
            end
        end
    end

    // Channel pointer and per-taxel retry budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_r    <= {CH_W{1'b0}};
            retry_r <= {RTY_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_in) begin
                        ch_r    <= {CH_W{1'b0}};
                        retry_r <= {RTY_W{1'b0}};
                    end else begin
                        ch_r    <= ch_r;
                    end
                end
                S_WAIT: begin
                    if (adc_valid_in) begin
                        retry_r <= {RTY_W{1'b0}};
                    end else begin
                        retry_r <= retry_r;
                    end
                end
                S_RECOVER: begin
                    if (rec_done_s && retry_ok_s) begin
                        retry_r <= retry_r + RTY_W'(1);
                    end else if (rec_done_s) begin
                        retry_r <= {RTY_W{1'b0}};
                    end else begin
                        retry_r <= retry_r;
                    end
                end
                S_NEXT: begin
                    if (last_ch_s) begin
                        ch_r <= {CH_W{1'b0}};
                    end else begin
                        ch_r <= ch_r + CH_W'(1);
                    end
                end
                default: begin
                    ch_r <= ch_r;
                end
            endcase
        end
    end

    // Registered strobes and levels, aligned with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_rd_r   <= 1'b0;
            adc_rst_r    <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            pulse_rd_r   <= (next_state_s == S_TRIGGER);
            adc_rst_r    <= (next_state_s == S_RECOVER);
            frame_done_r <= (next_state_s == S_NEXT) && last_ch_s;
            busy_r       <= (next_state_s != S_IDLE);
        end
    end

    // Sample stream: good results from the reader or zero-data error tags for skips.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_valid_r <= 1'b0;
            sample_ch_r    <= {CH_W{1'b0}};
            sample_data_r  <= 12'h000;
            sample_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                sample_valid_r <= 1'b1;
                sample_ch_r    <= ch_r;
                sample_data_r  <= adc_data_in;
                sample_err_r   <= 1'b0;
            end else if (skip_s) begin
                sample_valid_r <= 1'b1;
                sample_ch_r    <= ch_r;
                sample_data_r  <= 12'h000;
                sample_err_r   <= 1'b1;
            end else begin
                sample_valid_r <= 1'b0;
            end
        end
    end

    // Health reporting: sticky skip flag and saturating recovery count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_r     <= 1'b0;
            err_count_r <= 8'h00;
        end else begin
            if (start_ok_s) begin
                fault_r <= 1'b0;
            end else if (skip_s) begin
                fault_r <= 1'b1;
            end else begin
                fault_r <= fault_r;
            end
            if (rec_entry_s) begin
                err_count_r <= sat_inc8(err_count_r);
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    assign mux_sel_out      = ch_r;
    assign adc_pulse_rd_out = pulse_rd_r;
    assign adc_rst_out      = adc_rst_r;
    assign sample_valid_out = sample_valid_r;
    assign sample_ch_out    = sample_ch_r;
    assign sample_data_out  = sample_data_r;
    assign sample_err_out   = sample_err_r;
    assign frame_done_out   = frame_done_r;
    assign busy_out         = busy_r;
    assign fault_out        = fault_r;
    assign err_count_out    = err_count_r;

endmodule

// File: tb/tb_tactile_scan_ctrl.sv
// Bench for tactile_scan_ctrl: a scripted ADC reader answers each conversion
// request from a per-attempt plan; expected samples, trigger spacing, recovery
// pulses and counters are derived from that plan with plain arithmetic.
module tb_tactile_scan_ctrl;

    localparam int NUM_CH    = 16;
    localparam int SETTLE    = 8;
    localparam int TIMEOUT   = 64;
    localparam int MAX_RETRY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic        continuous_in = 1'b0;
    logic        adc_valid_in = 1'b0;
    logic        adc_error_in = 1'b0;
    logic [11:0] adc_data_in = 12'h000;
    logic [3:0]  mux_sel_out;
    logic        adc_pulse_rd_out;
    logic        adc_rst_out;
    logic        sample_valid_out;
    logic [3:0]  sample_ch_out;
    logic [11:0] sample_data_out;
    logic        sample_err_out;
    logic        frame_done_out;
    logic        busy_out;
    logic        fault_out;
    logic [7:0]  err_count_out;

    tactile_scan_ctrl #(
        .NUM_CH(NUM_CH), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .continuous_in(continuous_in),
        .adc_valid_in(adc_valid_in), .adc_error_in(adc_error_in), .adc_data_in(adc_data_in),
        .mux_sel_out(mux_sel_out), .adc_pulse_rd_out(adc_pulse_rd_out), .adc_rst_out(adc_rst_out),
        .sample_valid_out(sample_valid_out), .sample_ch_out(sample_ch_out),
        .sample_data_out(sample_data_out), .sample_err_out(sample_err_out),
        .frame_done_out(frame_done_out), .busy_out(busy_out), .fault_out(fault_out),
        .err_count_out(err_count_out)
    );

    always #5 clk = ~clk;

    // kind: 0 good result, 1 sticky error, 2 no answer, 3 valid+error together
    typedef struct {
        int          kind;
        int          lat;
        logic [11:0] data;
    } att_t;

    att_t plan_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   pulse_cyc_q[$];
    int   pulse_ch_q[$];
    int   samp_q[$];
    int   rst_len_q[$];
    int   fd_cnt = 0;
    int   fd_bad = 0;
    int   exp_samp_q[$];
    int   exp_gap_q[$];
    int   exp_ch_q[$];
    int   exp_rec = 0;
    bit   exp_skip = 1'b0;
    int   exp_err = 0;
    bit   stray_en = 1'b0;

    function automatic int pack(input int c, input logic [11:0] d, input logic e);
        return (c << 13) | (int'(d) << 1) | int'(e);
    endfunction

    function automatic int outs_or();
        return int'(|{mux_sel_out, adc_pulse_rd_out, adc_rst_out, sample_valid_out, sample_ch_out,
                      sample_data_out, sample_err_out, frame_done_out, busy_out, fault_out, err_count_out});
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scripted reader: answers each request per the plan; error is sticky until reset.
    initial begin : reader
        int   cnt;
        bit   pend;
        bit   clr_next;
        att_t cur;
        cnt = 0; pend = 1'b0; clr_next = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0; clr_next = 1'b0;
                adc_valid_in = 1'b0; adc_error_in = 1'b0;
            end else begin
                adc_valid_in = 1'b0;
                if (clr_next) begin
                    adc_error_in = 1'b0;
                    clr_next = 1'b0;
                end
                if (adc_rst_out) adc_error_in = 1'b0;
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend = 1'b0;
                        case (cur.kind)
                            0: begin adc_valid_in = 1'b1; adc_data_in = cur.data; end
                            1: adc_error_in = 1'b1;
                            3: begin adc_valid_in = 1'b1; adc_data_in = cur.data;
                                     adc_error_in = 1'b1; clr_next = 1'b1; end
                            default: ;
                        endcase
                    end
                end else if (stray_en && sample_valid_out) begin
                    adc_valid_in = 1'b1;
                    adc_data_in = 12'($urandom);
                end
                if (adc_pulse_rd_out) begin
                    if (plan_q.size() > 0) begin
                        cur = plan_q.pop_front();
                        pend = (cur.kind != 2);
                        cnt = cur.lat;
                    end else begin
                        pend = 1'b0;
                    end
                end
            end
        end
    end

    // Observation recorder.
    initial begin : monitor
        int cur_len;
        cur_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur_len = 0;
            end else begin
                if (adc_pulse_rd_out) begin
                    pulse_cyc_q.push_back(cyc);
                    pulse_ch_q.push_back(int'(mux_sel_out));
                end
                if (sample_valid_out)
                    samp_q.push_back(pack(int'(sample_ch_out), sample_data_out, sample_err_out));
                if (frame_done_out) begin
                    fd_cnt++;
                    if (!(sample_valid_out && sample_ch_out == 4'(NUM_CH - 1))) fd_bad++;
                end
                if (adc_rst_out) cur_len++;
                else if (cur_len > 0) begin
                    rst_len_q.push_back(cur_len);
                    cur_len = 0;
                end
            end
        end
    end

    task automatic clear_all();
        plan_q.delete(); pulse_cyc_q.delete(); pulse_ch_q.delete(); samp_q.delete();
        rst_len_q.delete(); exp_samp_q.delete(); exp_gap_q.delete(); exp_ch_q.delete();
        exp_rec = 0; exp_skip = 1'b0;
    endtask

    // Builds one frame of reader behaviour plus the outcome the scan rules predict.
    task automatic gen_frame(input int mode);
        att_t a;
        int   fails;
        bit   done;
        int   r;
        int   resp;
        for (int c = 0; c < NUM_CH; c++) begin
            fails = 0;
            done = 1'b0;
            while (!done) begin
                a.kind = 0; a.lat = 20; a.data = 12'hA5A;
                case (mode)
                    1: if (c == 3 && fails == 0) begin a.kind = 1; a.lat = $urandom_range(1, 30); end
                    2: if (c == 5) a.kind = 2;
                    3: begin
                        r = $urandom_range(0, 99);
                        a.kind = (r < 70) ? 0 : (r < 85) ? 1 : (r < 95) ? 3 : 2;
                        a.lat = $urandom_range(1, 40);
                        a.data = 12'($urandom);
                    end
                    4: begin a.kind = 1; a.lat = 1; end
                    5: begin a.kind = 3; a.lat = $urandom_range(1, 40); a.data = 12'($urandom); end
                    default: ;
                endcase
                plan_q.push_back(a);
                exp_ch_q.push_back(c);
                if (a.kind == 0 || a.kind == 3) begin
                    exp_samp_q.push_back(pack(c, a.data, 1'b0));
                    exp_gap_q.push_back(a.lat + 1 + SETTLE + 1);
                    done = 1'b1;
                end else begin
                    fails++;
                    exp_rec++;
                    resp = (a.kind == 1) ? a.lat : TIMEOUT;
                    if (fails > MAX_RETRY) begin
                        exp_samp_q.push_back(pack(c, 12'h000, 1'b1));
                        exp_skip = 1'b1;
                        exp_gap_q.push_back(resp + 2 + 1 + SETTLE + 1);
                        done = 1'b1;
                    end else begin
                        exp_gap_q.push_back(resp + 2 + SETTLE + 1);
                    end
                end
            end
        end
    endtask

    task automatic verify(input int nfr, input int fd0);
        int m;
        chk("sample_count", samp_q.size(), exp_samp_q.size());
        m = (samp_q.size() < exp_samp_q.size()) ? samp_q.size() : exp_samp_q.size();
        for (int i = 0; i < m; i++) chk("sample", samp_q[i], exp_samp_q[i]);
        chk("trig_count", pulse_cyc_q.size(), exp_ch_q.size());
        m = (pulse_cyc_q.size() < exp_ch_q.size()) ? pulse_cyc_q.size() : exp_ch_q.size();
        for (int i = 0; i < m; i++) chk("trig_ch", pulse_ch_q[i], exp_ch_q[i]);
        if (m > 0) chk("start_to_trig", pulse_cyc_q[0] - start_cyc, SETTLE + 1);
        for (int i = 1; i < m; i++) chk("trig_gap", pulse_cyc_q[i] - pulse_cyc_q[i-1], exp_gap_q[i-1]);
        chk("rst_pulses", rst_len_q.size(), exp_rec);
        foreach (rst_len_q[i]) chk("rst_len", rst_len_q[i], 2);
        chk("err_count", int'(err_count_out), exp_err);
        chk("fault", int'(fault_out), int'(exp_skip));
        chk("busy_idle", int'(busy_out), 0);
        chk("frame_done_count", fd_cnt - fd0, nfr);
        chk("frame_done_align", fd_bad, 0);
    endtask

    task automatic run(input int nfr, input bit poke);
        int fd0;
        int n;
        fd0 = fd_cnt;
        continuous_in = (nfr > 1);
        start_cyc = cyc;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        if (poke) begin
            repeat (30) step();
            start_in = 1'b1;
            step();
            start_in = 1'b0;
        end
        n = 0;
        while (fd_cnt < fd0 + 1 && n < 8000) begin step(); n++; end
        if (nfr > 1) begin
            repeat (20) step();
            continuous_in = 1'b0;
            n = 0;
            while (fd_cnt < fd0 + 2 && n < 8000) begin step(); n++; end
        end
        repeat (5) step();
        if (exp_gap_q.size() > 0) void'(exp_gap_q.pop_back());
        exp_err = (exp_err + exp_rec > 255) ? 255 : exp_err + exp_rec;
        verify(nfr, fd0);
    endtask

    initial begin : main
        int fd0;
        int n;
        // Reset state
        repeat (3) step();
        chk("reset_outputs", outs_or(), 0);
        rst_n = 1'b1;
        repeat (2) step();
        chk("reset_idle_busy", int'(busy_out), 0);

        // Clean frame, fixed reader latency
        clear_all(); gen_frame(0); run(1, 1'b0);
        // One sync error on ch 3
        clear_all(); gen_frame(1); run(1, 1'b0);
        // Reader silent on ch 5 -> skip
        clear_all(); gen_frame(2); run(1, 1'b0);
        // Back-to-back random frames, continuous dropped mid second frame, start poked while busy
        stray_en = 1'b1;
        clear_all(); gen_frame(3); gen_frame(3); run(2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            clear_all(); gen_frame(3); run(1, 1'b1);
        end
        stray_en = 1'b0;

        // Asynchronous reset while waiting on ch 7
        clear_all(); gen_frame(0);
        fd0 = fd_cnt;
        start_in = 1'b1; step(); start_in = 1'b0;
        n = 0;
        while (pulse_cyc_q.size() < 8 && n < 2000) begin step(); n++; end
        chk("reached_ch7", pulse_cyc_q.size(), 8);
        repeat (3) step();
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outputs", outs_or(), 0);
        step(); step();
        rst_n = 1'b1;
        plan_q.delete();
        repeat (150) step();
        chk("reset_abort_samples", samp_q.size(), 7);
        chk("reset_abort_frame_done", fd_cnt - fd0, 0);
        chk("reset_abort_busy", int'(busy_out), 0);
        chk("reset_abort_err_count", int'(err_count_out), 0);
        exp_err = 0;

        // Saturation: every attempt errors, 48 recoveries per frame
        for (int k = 0; k < 7; k++) begin
            clear_all(); gen_frame(4); run(1, 1'b0);
        end
        // Valid and error together: valid wins, no recovery
        clear_all(); gen_frame(5); run(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
